// File: rtl/controlador_configuracion_if.sv
// Button/output bundle between the user-input front end and the configuration controller.
// The master drives the button pulses; the slave (the controller) drives the register-group controls.
interface controlador_configuracion_if;
    logic       btn_hora;
    logic       btn_fecha;
    logic       btn_timer;
    logic       btn_der;
    logic       btn_izq;
    logic       btn_arriba;
    logic       btn_abajo;
    logic [2:0] funcion_conf;
    logic [1:0] campo;
    logic       inc;
    logic       dec;
    logic       escribir;
    logic       en_conf;

    modport master (
        output btn_hora, btn_fecha, btn_timer, btn_der, btn_izq, btn_arriba, btn_abajo,
        input  funcion_conf, campo, inc, dec, escribir, en_conf
    );

    modport slave (
        input  btn_hora, btn_fecha, btn_timer, btn_der, btn_izq, btn_arriba, btn_abajo,
        output funcion_conf, campo, inc, dec, escribir, en_conf
    );
endinterface

// File: rtl/controlador_configuracion.sv
// Clock/calendar/timer configuration controller: selects a register group and field, issues inc/dec and commit pulses.
// Optional inactivity timeout compiled in with `define TIMEOUT_CONF_EN.
module controlador_configuracion #(
    parameter int unsigned TIMEOUT_CICLOS = 100_000_000
) (
    input  logic                          clk,
    input  logic                          reset,
    controlador_configuracion_if.slave    bus
);

    typedef enum logic [2:0] {
        IDLE,
        CONF_HORA,
        CONF_FECHA,
        CONF_TIMER,
        COMMIT
    } estado_t;

    estado_t    estado_q;
    logic [2:0] funcion_q;
    logic [1:0] campo_q;
    logic       inc_q;
    logic       dec_q;
    logic       escribir_q;
    logic       en_conf_q;

    logic       en_edicion;
    logic       cualquier_boton;
    logic       boton_salida;
    logic       timeout;
    logic [1:0] ultimo_campo;
    logic [1:0] campo_d;

    assign en_edicion      = (estado_q == CONF_HORA) || (estado_q == CONF_FECHA) ||
                             (estado_q == CONF_TIMER);
    assign cualquier_boton = bus.btn_hora | bus.btn_fecha | bus.btn_timer | bus.btn_der |
                             bus.btn_izq | bus.btn_arriba | bus.btn_abajo;
    // Fecha has four fields (dia, mes, jahr, dia_semana); hora and timer have three.
    assign ultimo_campo    = (estado_q == CONF_FECHA) ? 2'd3 : 2'd2;

    // NOTE: always_comb assigns every output first, so no path leaves a latch behind.
    always_comb begin
        boton_salida = 1'b0;
        unique case (estado_q)
            CONF_HORA:  boton_salida = bus.btn_hora;
            CONF_FECHA: boton_salida = bus.btn_fecha;
            CONF_TIMER: boton_salida = bus.btn_timer;
            default:    boton_salida = 1'b0;
        endcase
    end

    always_comb begin
        campo_d = campo_q;
        if (bus.btn_der && !bus.btn_izq) begin
            campo_d = (campo_q == ultimo_campo) ? 2'd0 : campo_q + 2'd1;
        end else if (bus.btn_izq && !bus.btn_der) begin
            campo_d = (campo_q == 2'd0) ? ultimo_campo : campo_q - 2'd1;
        end
    end

`ifdef TIMEOUT_CONF_EN
    localparam int unsigned CNT_W = (TIMEOUT_CICLOS > 2) ? $clog2(TIMEOUT_CICLOS) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Idle time only accumulates while editing; any button press restarts it.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!en_edicion || cualquier_boton) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout = en_edicion && !cualquier_boton && (cnt_q == CNT_W'(TIMEOUT_CICLOS - 1));
`else
    logic unused_timeout_ciclos;

    assign unused_timeout_ciclos = (TIMEOUT_CICLOS != 0) & cualquier_boton;
    assign timeout               = 1'b0;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q   <= IDLE;
            funcion_q  <= 3'b000;
            campo_q    <= 2'd0;
            inc_q      <= 1'b0;
            dec_q      <= 1'b0;
            escribir_q <= 1'b0;
            en_conf_q  <= 1'b0;
        end else begin
            inc_q      <= 1'b0;
            dec_q      <= 1'b0;
            escribir_q <= 1'b0;
            unique case (estado_q)
                IDLE: begin
                    campo_q <= 2'd0;
                    if (bus.btn_hora) begin
                        estado_q  <= CONF_HORA;
                        funcion_q <= 3'b001;
                        en_conf_q <= 1'b1;
                    end else if (bus.btn_fecha) begin
                        estado_q  <= CONF_FECHA;
                        funcion_q <= 3'b010;
                        en_conf_q <= 1'b1;
                    end else if (bus.btn_timer) begin
                        estado_q  <= CONF_TIMER;
                        funcion_q <= 3'b100;
                        en_conf_q <= 1'b1;
                    end
                end
                CONF_HORA, CONF_FECHA, CONF_TIMER: begin
                    inc_q <= bus.btn_arriba & ~bus.btn_abajo;
                    dec_q <= bus.btn_abajo & ~bus.btn_arriba;
                    if (timeout) begin
                        estado_q  <= IDLE;
                        funcion_q <= 3'b000;
                        campo_q   <= 2'd0;
                        en_conf_q <= 1'b0;
                    end else if (boton_salida) begin
                        estado_q   <= COMMIT;
                        escribir_q <= 1'b1;
                    end else begin
                        campo_q <= campo_d;
                    end
                end
                COMMIT: begin
                    estado_q  <= IDLE;
                    funcion_q <= 3'b000;
                    campo_q   <= 2'd0;
                    en_conf_q <= 1'b0;
                end
                default: begin
                    estado_q  <= IDLE;
                    funcion_q <= 3'b000;
                    campo_q   <= 2'd0;
                    en_conf_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.funcion_conf = funcion_q;
    assign bus.campo        = campo_q;
    assign bus.inc          = inc_q;
    assign bus.dec          = dec_q;
    assign bus.escribir     = escribir_q;
    assign bus.en_conf      = en_conf_q;

endmodule

// File: tb/tb_controlador_configuracion.sv
// Scoreboard bench for controlador_configuracion: each stimulus cycle queues its expected outputs,
// and a monitor compares them one cycle-edge later.
module tb_controlador_configuracion;

    localparam int unsigned TIMEOUT_TB = 16;

    localparam logic [6:0] NADA   = 7'b0000000;
    localparam logic [6:0] B_HORA = 7'b1000000;
    localparam logic [6:0] B_FEC  = 7'b0100000;
    localparam logic [6:0] B_TIM  = 7'b0010000;
    localparam logic [6:0] B_DER  = 7'b0001000;
    localparam logic [6:0] B_IZQ  = 7'b0000100;
    localparam logic [6:0] B_ARR  = 7'b0000010;
    localparam logic [6:0] B_ABA  = 7'b0000001;

    typedef struct packed {
        logic [2:0] funcion;
        logic [1:0] campo;
        logic       inc;
        logic       dec;
        logic       escribir;
        logic       en_conf;
    } salida_t;

    logic clk;
    logic reset;

    controlador_configuracion_if cfg_if ();

    controlador_configuracion #(
        .TIMEOUT_CICLOS(TIMEOUT_TB)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (cfg_if)
    );

    salida_t esperado_q[$];
    string   nombre_q[$];
    int      checks = 0;
    int      passed = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic salida_t mk(input logic [2:0] f, input logic [1:0] c, input logic i,
                                   input logic d, input logic w, input logic e);
        salida_t s;
        s.funcion  = f;
        s.campo    = c;
        s.inc      = i;
        s.dec      = d;
        s.escribir = w;
        s.en_conf  = e;
        return s;
    endfunction

    // Drive one cycle of inputs and queue the outputs expected right after the next rising edge.
    task automatic paso(input logic rst, input logic [6:0] b, input salida_t e, input string n);
        @(negedge clk);
        reset = rst;
        {cfg_if.btn_hora, cfg_if.btn_fecha, cfg_if.btn_timer, cfg_if.btn_der,
         cfg_if.btn_izq, cfg_if.btn_arriba, cfg_if.btn_abajo} = b;
        esperado_q.push_back(e);
        nombre_q.push_back(n);
    endtask

    // Monitor: one queued expectation per clock edge, sampled just after the edge.
    initial begin
        salida_t act;
        salida_t exp_v;
        string   nom;
        forever begin
            @(posedge clk);
            #1;
            if (esperado_q.size() > 0) begin
                exp_v = esperado_q.pop_front();
                nom   = nombre_q.pop_front();
                act   = {cfg_if.funcion_conf, cfg_if.campo, cfg_if.inc, cfg_if.dec,
                         cfg_if.escribir, cfg_if.en_conf};
                checks++;
                if (act === exp_v) begin
                    passed++;
                end else begin
                    $display("FAIL %s: got f=%b c=%0d inc=%b dec=%b wr=%b en=%b, expected f=%b c=%0d inc=%b dec=%b wr=%b en=%b",
                             nom, act.funcion, act.campo, act.inc, act.dec, act.escribir, act.en_conf,
                             exp_v.funcion, exp_v.campo, exp_v.inc, exp_v.dec, exp_v.escribir, exp_v.en_conf);
                end
            end
        end
    end

    initial begin
        salida_t idle0;
        idle0 = mk(3'b000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        {cfg_if.btn_hora, cfg_if.btn_fecha, cfg_if.btn_timer, cfg_if.btn_der,
         cfg_if.btn_izq, cfg_if.btn_arriba, cfg_if.btn_abajo} = NADA;

        paso(1'b1, NADA, idle0, "reset");
        paso(1'b1, B_HORA, idle0, "reset_over_hora");

        // Hora edit: cursor right twice, one increment, commit.
        paso(1'b0, B_HORA, mk(3'b001, 2'd0, 0, 0, 0, 1), "hora_enter");
        paso(1'b0, B_DER,  mk(3'b001, 2'd1, 0, 0, 0, 1), "hora_der1");
        paso(1'b0, B_DER,  mk(3'b001, 2'd2, 0, 0, 0, 1), "hora_der2");
        paso(1'b0, B_ARR,  mk(3'b001, 2'd2, 1, 0, 0, 1), "hora_inc");
        paso(1'b0, NADA,   mk(3'b001, 2'd2, 0, 0, 0, 1), "hora_inc_once");
        paso(1'b0, B_HORA, mk(3'b001, 2'd2, 0, 0, 1, 1), "hora_commit");
        paso(1'b0, NADA,   idle0, "hora_back_idle");

        // Buttons in IDLE other than mode buttons do nothing.
        paso(1'b0, B_ARR | B_DER, idle0, "idle_ignores_arr_der");

        // Fecha cursor wraps over four fields; simultaneous der+izq holds.
        paso(1'b0, B_FEC, mk(3'b010, 2'd0, 0, 0, 0, 1), "fecha_enter");
        paso(1'b0, B_IZQ, mk(3'b010, 2'd3, 0, 0, 0, 1), "fecha_izq_wrap");
        paso(1'b0, B_DER, mk(3'b010, 2'd0, 0, 0, 0, 1), "fecha_der_wrap");
        paso(1'b0, B_DER | B_IZQ, mk(3'b010, 2'd0, 0, 0, 0, 1), "fecha_der_izq");
        paso(1'b0, B_DER, mk(3'b010, 2'd1, 0, 0, 0, 1), "fecha_der");
        paso(1'b0, B_HORA, mk(3'b010, 2'd1, 0, 0, 0, 1), "fecha_ignores_hora");
        paso(1'b0, B_FEC, mk(3'b010, 2'd1, 0, 0, 1, 1), "fecha_commit");
        paso(1'b0, NADA, idle0, "fecha_back_idle");

        // Priority hora over timer; foreign mode button ignored; mode button in COMMIT ignored.
        paso(1'b0, B_HORA | B_TIM, mk(3'b001, 2'd0, 0, 0, 0, 1), "prio_hora");
        paso(1'b0, B_TIM, mk(3'b001, 2'd0, 0, 0, 0, 1), "hora_ignores_timer");
        paso(1'b0, B_IZQ, mk(3'b001, 2'd2, 0, 0, 0, 1), "hora_izq_wrap");
        paso(1'b0, B_HORA, mk(3'b001, 2'd2, 0, 0, 1, 1), "hora_commit2");
        paso(1'b0, B_FEC, idle0, "commit_ignores_fecha");
        paso(1'b0, NADA, idle0, "still_idle");
        paso(1'b0, B_FEC | B_TIM, mk(3'b010, 2'd0, 0, 0, 0, 1), "prio_fecha");
        paso(1'b0, B_FEC, mk(3'b010, 2'd0, 0, 0, 1, 1), "fecha_commit2");
        paso(1'b0, NADA, idle0, "fecha_back_idle2");

        // Timer: arr+aba cancel, lone aba gives one dec pulse.
        paso(1'b0, B_TIM, mk(3'b100, 2'd0, 0, 0, 0, 1), "timer_enter");
        paso(1'b0, B_ARR | B_ABA, mk(3'b100, 2'd0, 0, 0, 0, 1), "timer_arr_aba");
        paso(1'b0, B_ABA, mk(3'b100, 2'd0, 0, 1, 0, 1), "timer_dec");
        paso(1'b0, NADA, mk(3'b100, 2'd0, 0, 0, 0, 1), "timer_dec_once");
        paso(1'b0, B_TIM, mk(3'b100, 2'd0, 0, 0, 1, 1), "timer_commit");
        paso(1'b0, NADA, idle0, "timer_back_idle");

        // Reset during fecha edit, together with the commit button, aborts without escribir.
        paso(1'b0, B_FEC, mk(3'b010, 2'd0, 0, 0, 0, 1), "fecha_enter3");
        paso(1'b0, B_DER, mk(3'b010, 2'd1, 0, 0, 0, 1), "fecha_der3");
        paso(1'b1, B_FEC, idle0, "reset_in_fecha");
        paso(1'b0, NADA, idle0, "after_reset_abort");

        // Inactivity behaviour.
        paso(1'b0, B_TIM, mk(3'b100, 2'd0, 0, 0, 0, 1), "timer_enter_to");
`ifdef TIMEOUT_CONF_EN
        for (int k = 1; k < 16; k++) begin
            paso(1'b0, NADA, mk(3'b100, 2'd0, 0, 0, 0, 1), "timeout_wait");
        end
        paso(1'b0, NADA, idle0, "timeout_expire");
        paso(1'b0, NADA, idle0, "timeout_no_commit");

        // A button press restarts the inactivity count.
        paso(1'b0, B_TIM, mk(3'b100, 2'd0, 0, 0, 0, 1), "timer_enter_to2");
        for (int k = 0; k < 10; k++) begin
            paso(1'b0, NADA, mk(3'b100, 2'd0, 0, 0, 0, 1), "timeout_wait2");
        end
        paso(1'b0, B_DER, mk(3'b100, 2'd1, 0, 0, 0, 1), "timeout_restart");
        for (int k = 1; k < 16; k++) begin
            paso(1'b0, NADA, mk(3'b100, 2'd1, 0, 0, 0, 1), "timeout_wait3");
        end
        paso(1'b0, NADA, idle0, "timeout_expire2");
`else
        for (int k = 0; k < 1000; k++) begin
            paso(1'b0, NADA, mk(3'b100, 2'd0, 0, 0, 0, 1), "no_timeout_persist");
        end
        paso(1'b0, B_TIM, mk(3'b100, 2'd0, 0, 0, 1, 1), "timer_commit_late");
        paso(1'b0, NADA, idle0, "timer_back_idle_late");
`endif

        @(posedge clk);
        #2;
        checks++;
        if (esperado_q.size() == 0) begin
            passed++;
        end else begin
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", esperado_q.size());
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/controlador_configuracion.md
CONTROLADOR_CONFIGURACION -- requirements
Module: controlador_configuracion

Interface
REQ-001 SHALL have parameter TIMEOUT_CICLOS, default 100_000_000, giving the inactivity limit in clk cycles (1 s at 100 MHz).
REQ-002 SHALL have port clk  input  1  the single system clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port btn_hora  input  1  one-cycle pulse that enters or leaves time-of-day configuration.
REQ-005 SHALL have port btn_fecha  input  1  one-cycle pulse that enters or leaves date configuration.
REQ-006 SHALL have port btn_timer  input  1  one-cycle pulse that enters or leaves timer configuration.
REQ-007 SHALL have ports btn_der / btn_izq  input  1 each  one-cycle pulses that move the field cursor right or left.
REQ-008 SHALL have ports btn_arriba / btn_abajo  input  1 each  one-cycle pulses that increment or decrement the selected field.
REQ-009 SHALL have port funcion_conf  output  3  register-group select: 000 none, 001 hora, 010 fecha, 100 timer.
REQ-010 SHALL have port campo  output  2  index of the selected field within the active group.
REQ-011 SHALL have ports inc / dec  output  1 each  one-cycle pulses to the selected field register.
REQ-012 SHALL have port escribir  output  1  one-cycle pulse that commits the edited group to the RTC.
REQ-013 SHALL have port en_conf  output  1  high while any configuration mode is active.

Function
REQ-014 SHALL implement an FSM with states IDLE, CONF_HORA, CONF_FECHA, CONF_TIMER and COMMIT; all outputs SHALL be registered.
REQ-015 In IDLE, btn_hora, btn_fecha or btn_timer SHALL move the FSM to the matching CONF state on the next edge, with campo=0.
REQ-016 If several mode buttons pulse together in IDLE, priority SHALL be hora > fecha > timer.
REQ-017 funcion_conf SHALL be 001, 010 or 100 in CONF_HORA, CONF_FECHA and CONF_TIMER respectively, hold that value during COMMIT, and be 000 in IDLE.
REQ-018 The field count SHALL be 3 in hora (seg, min, hora), 4 in fecha (dia, mes, jahr, dia_semana) and 3 in timer (seg, min, hora).
REQ-019 btn_der SHALL increment campo, wrapping from the last field to 0.
REQ-020 btn_izq SHALL decrement campo, wrapping from 0 to the last field.
REQ-021 If btn_der and btn_izq pulse in the same cycle, campo SHALL be unchanged.
REQ-022 Each btn_arriba or btn_abajo pulse in a CONF state SHALL produce exactly one inc or dec pulse, one cycle later (latency 1).
REQ-023 If btn_arriba and btn_abajo pulse in the same cycle, neither inc nor dec SHALL be asserted.
REQ-024 inc, dec and cursor buttons SHALL be ignored in IDLE and COMMIT.
REQ-025 In a CONF state, the mode button of the active group SHALL move the FSM to COMMIT.
REQ-026 In a CONF state, the mode buttons of the other groups SHALL be ignored.
REQ-027 COMMIT SHALL last exactly one cycle with escribir=1, then return to IDLE with campo=0.
REQ-028 en_conf SHALL be 1 in CONF states and COMMIT, and 0 in IDLE.
REQ-029 A mode button pulse in the COMMIT cycle SHALL be ignored.

Reset
REQ-030 On reset=1 at a clock edge, the FSM SHALL go to IDLE with funcion_conf=000, campo=0, inc=0, dec=0, escribir=0, en_conf=0 and the timeout counter cleared.
REQ-031 Reset during a CONF state SHALL abort the edit and SHALL NOT assert escribir.
REQ-032 Reset SHALL take priority over every button input in the same cycle.

Configuration
REQ-033 The macro TIMEOUT_CONF_EN SHALL compile the inactivity timeout in or out.
REQ-034 When TIMEOUT_CONF_EN is defined, a counter SHALL clear on entry to a CONF state and on any button pulse, and count once per cycle otherwise.
REQ-035 When TIMEOUT_CONF_EN is defined and the counter reaches TIMEOUT_CICLOS-1, the FSM SHALL return to IDLE without COMMIT and with no escribir pulse.
REQ-036 When TIMEOUT_CONF_EN is undefined, no counter SHALL exist and CONF states SHALL persist indefinitely.

Verification
REQ-037 Scenario: reset, then btn_hora, two btn_der, one btn_arriba, btn_hora -> funcion_conf=001, campo 0->1->2, one inc pulse one cycle after btn_arriba, then escribir=1 for one cycle with funcion_conf=001, then funcion_conf=000.
REQ-038 Scenario: btn_fecha, btn_izq -> campo=3; btn_der -> campo=0; btn_der+btn_izq together -> campo stays 0.
REQ-039 Scenario: btn_hora+btn_timer in IDLE -> funcion_conf=001; btn_timer while in CONF_HORA -> no state change.
REQ-040 Scenario: TIMEOUT_CONF_EN defined, TIMEOUT_CICLOS=16, btn_timer then idle -> funcion_conf returns to 000 after 16 cycles with escribir never high; macro undefined -> still 100 after 1000 cycles.
REQ-041 Scenario: reset asserted in CONF_FECHA in the same cycle as btn_fecha -> IDLE next edge, escribir=0, all outputs 0.
REQ-042 Scenario: btn_arriba+btn_abajo together in CONF_TIMER -> inc=0 and dec=0; btn_abajo alone -> dec=1 for exactly one cycle.
